// File: rtl/vga_output_module.sv
// vga_output_module: 640x480@60 VGA timing, framebuffer coordinate issue and DAC output registers
module vga_output_module #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [2:0]  color_in,
  output logic [16:0] output_module_coords,
  output logic        new_frame,
  output logic        vga_clk,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  logic       phase;
  logic [9:0] h, v;
  logic       pix_en, visible, hs_raw, vs_raw, h_last, v_last;
  assign pix_en  = phase;
  assign vga_clk = phase;
  assign h_last  = h == 10'(H_TOTAL - 1);
  assign v_last  = v == 10'(V_TOTAL - 1);
  assign visible = (h < 10'(H_VISIBLE)) && (v < 10'(V_VISIBLE));
  assign hs_raw  = !((h >= 10'(H_VISIBLE + H_FRONT)) && (h < 10'(H_VISIBLE + H_FRONT + H_SYNC)));
  assign vs_raw  = !((v >= 10'(V_VISIBLE + V_FRONT)) && (v < 10'(V_VISIBLE + V_FRONT + V_SYNC)));
  // x in [16:8], y in [7:0]; each framebuffer pixel covers a 2x2 screen block
  assign output_module_coords = visible ? {h[9:1], v[8:1]} : 17'd0;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      phase       <= 1'b0;
      h           <= '0;
      v           <= '0;
      new_frame   <= 1'b0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
    end else begin
      phase     <= ~phase;
      new_frame <= pix_en && h_last && (v == 10'(V_VISIBLE + V_FRONT - 1));
      if (pix_en) begin
        h           <= h_last ? '0 : h + 10'd1;
        v           <= h_last ? (v_last ? '0 : v + 10'd1) : v;
        vga_hs      <= hs_raw;
        vga_vs      <= vs_raw;
        vga_blank_n <= visible;
        // color_in answers the coordinate issued for this same pixel
        vga_r       <= visible ? {8{color_in[2]}} : 8'd0;
        vga_g       <= visible ? {8{color_in[1]}} : 8'd0;
        vga_b       <= visible ? {8{color_in[0]}} : 8'd0;
      end
    end
  end
endmodule

// File: tb/tb_vga_output_module.sv
// tb_vga_output_module: scoreboard bench; expectations keyed by segment/cycle, matched by a negedge monitor
module tb_vga_output_module;
  localparam int VV = 6, VF = 1, VS = 2, VB = 1;
  localparam longint SEG = 1000000;
  localparam int K_RST = 0, K_VCLK = 1, K_COORD = 2, K_DAC = 3, K_HSF = 4, K_VSF = 5, K_NF = 6,
                 K_HSPER = 7, K_HSLOW = 8, K_BLANK = 9, K_VSLOW = 10, K_VSPER = 11, K_NFW = 12, K_NFPER = 13;
  string names [14] = '{"rst_state", "vga_clk", "coords", "dac_rgb", "hs_fall_at", "vs_fall_at", "new_frame_at",
                        "hs_period", "hs_low", "blank_high", "vs_low", "vs_period", "new_frame_width", "new_frame_period"};
  typedef struct {int kind; longint key; longint val;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  logic clk = 0, rst = 1, xmode = 0;
  logic [2:0] color_in = 3'b0;
  logic [16:0] coords;
  logic new_frame, vga_clk, vga_hs, vga_vs, vga_blank_n;
  logic [7:0] vga_r, vga_g, vga_b;
  longint rst_v;

  vga_output_module #(.V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)) dut (
    .Clk(clk), .Reset(rst), .color_in(color_in), .output_module_coords(coords), .new_frame(new_frame),
    .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b));

  always #5 clk = ~clk;

  always @(posedge clk) color_in <= xmode ? coords[10:8] : 3'b101;

  function automatic void push(int k, longint key, longint v);
    exp_t e;
    e.kind = k; e.key = key; e.val = v;
    q.push_back(e);
  endfunction

  function automatic void observe(int k, longint key, longint act);
    for (int i = 0; i < q.size(); i++)
      if (q[i].kind == k && q[i].key == key) begin
        total++;
        if (act != q[i].val) begin
          bad++;
          $display("FAIL %s key=%0d got=%0h want=%0h", names[k], key, act, q[i].val);
        end
        q.delete(i);
        return;
      end
  endfunction

  function automatic longint co(int x, int y);
    return longint'({x[8:0], y[7:0]});
  endfunction

  longint since = 0, seg = 0, key, base;
  longint t_hsf = -1, t_bl = -1, t_vsf = -1, t_nf = -1;
  logic rst_p = 0, hs_p = 1, vs_p = 1, bl_p = 0, nf_p = 0;

  always @(negedge clk) begin
    if (rst) begin
      since = 0; t_hsf = -1; t_bl = -1; t_vsf = -1; t_nf = -1;
    end else begin
      if (since == 0) seg++;
      since++;
    end
    key = seg * SEG + since;
    base = seg * SEG;
    if ((rst && rst_p) || (!rst && since == 1))
      observe(K_RST, key, longint'({vga_hs, vga_vs, vga_blank_n, vga_clk, new_frame, vga_r, vga_g, vga_b, coords}));
    if (!rst) begin
      observe(K_VCLK, key, longint'(vga_clk));
      observe(K_COORD, key, longint'(coords));
      observe(K_DAC, key, longint'({vga_r, vga_g, vga_b}));
      if (hs_p && !vga_hs) begin
        observe(K_HSF, key, 1);
        if (t_hsf >= 0) observe(K_HSPER, base, since - t_hsf);
        t_hsf = since;
      end
      if (!hs_p && vga_hs && t_hsf >= 0) observe(K_HSLOW, base, since - t_hsf);
      if (!bl_p && vga_blank_n) t_bl = since;
      if (bl_p && !vga_blank_n && t_bl >= 0) observe(K_BLANK, base, since - t_bl);
      if (vs_p && !vga_vs) begin
        observe(K_VSF, key, 1);
        if (t_vsf >= 0) observe(K_VSPER, base, since - t_vsf);
        t_vsf = since;
      end
      if (!vs_p && vga_vs && t_vsf >= 0) observe(K_VSLOW, base, since - t_vsf);
      if (!nf_p && new_frame) begin
        observe(K_NF, key, 1);
        if (t_nf >= 0) observe(K_NFPER, base, since - t_nf);
        t_nf = since;
      end
      if (nf_p && !new_frame && t_nf >= 0) observe(K_NFW, base, since - t_nf);
    end
    hs_p = vga_hs; vs_p = vga_vs; bl_p = vga_blank_n; nf_p = new_frame; rst_p = rst;
  end

  int dac_h [10] = '{0, 1, 2, 3, 4, 5, 7, 9, 639, 640};
  longint dac_v [10] = '{'h000000, 'h000000, 'h0000FF, 'h0000FF, 'h00FF00, 'h00FF00, 'h00FFFF, 'hFF0000, 'hFFFFFF, 'h000000};

  initial begin
    rst_v = longint'({2'b11, 44'd0});
    push(K_RST, 0, rst_v);
    push(K_RST, SEG + 1, rst_v);
    push(K_VCLK, SEG + 2, 1); push(K_VCLK, SEG + 3, 0);
    push(K_VCLK, SEG + 4, 1); push(K_VCLK, SEG + 5, 0);
    push(K_COORD, SEG + 2, co(0, 0));
    push(K_COORD, SEG + 1603, co(0, 0));
    push(K_COORD, SEG + 3207, co(1, 1));
    push(K_COORD, SEG + 5401, co(150, 1));
    push(K_COORD, SEG + 9279, co(319, 2));
    push(K_COORD, SEG + 9281, co(0, 0));
    push(K_COORD, SEG + 13001, co(0, 0));
    push(K_DAC, SEG + 3, 'hFF00FF);
    push(K_DAC, SEG + 23, 'hFF00FF);
    push(K_DAC, SEG + 1403, 0);
    push(K_DAC, SEG + 11223, 0);
    push(K_HSF, SEG + 1315, 1);
    for (int i = 0; i < 20; i++) begin
      push(K_HSPER, SEG, 1600);
      push(K_HSLOW, SEG, 192);
    end
    for (int i = 0; i < 12; i++) push(K_BLANK, SEG, 1280);
    push(K_VSF, SEG + 11203, 1);
    push(K_VSLOW, SEG, 3200); push(K_VSLOW, SEG, 3200);
    push(K_VSPER, SEG, 16000);
    push(K_NF, SEG + 11201, 1); push(K_NF, SEG + 27201, 1);
    push(K_NFW, SEG, 1); push(K_NFW, SEG, 1);
    push(K_NFPER, SEG, 16000);
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    repeat (37400) @(posedge clk);
    push(K_RST, 2 * SEG + 1, rst_v);
    push(K_COORD, 2 * SEG + 2, co(0, 0));
    push(K_COORD, 2 * SEG + 5401, co(150, 1));
    for (int i = 0; i < 10; i++) push(K_DAC, 2 * SEG + 2 * dac_h[i] + 3, dac_v[i]);
    push(K_HSF, 2 * SEG + 1315, 1);
    for (int i = 0; i < 5; i++) begin
      push(K_HSPER, 2 * SEG, 1600);
      push(K_HSLOW, 2 * SEG, 192);
    end
    push(K_VSF, 2 * SEG + 11203, 1);
    push(K_VSLOW, 2 * SEG, 3200);
    push(K_NF, 2 * SEG + 11201, 1);
    push(K_NFW, 2 * SEG, 1);
    #1 rst = 1; xmode = 1;
    @(posedge clk);
    #1 rst = 0;
    repeat (15000) @(posedge clk);
    repeat (2) @(negedge clk);
    foreach (q[i]) begin
      total++;
      bad++;
      $display("FAIL %s key=%0d got=none want=%0h", names[q[i].kind], q[i].key, q[i].val);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
